ecc_inv_arbiter: RTL and testbench

Shares one multi-cycle modular inversion unit (A → A⁻¹ mod P) among several ECC requesters, such as the point-add and point-double sequencers and the projective-to-affine converter. It arbitrates requests round-robin, validates operands, issues a one-cycle start pulse to the unit, and supervises it with a watchdog. It returns the result or an error to the granted requester over a valid/ready response channel. It sits between the requesters and the single inversion instance inside the ECC accelerator.

---
 rtl/ecc_ctrl_pkg.sv | 20 ++
 rtl/ecc_rr_arbiter.sv | 38 +++
 rtl/ecc_inv_arbiter.sv | 146 ++++++++++++++
 tb/tb_ecc_inv_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ctrl_pkg.sv
// ecc_ctrl_pkg: shared definitions for the ECC accelerator's shared-unit
// arbiters (inversion arbiter, multiplier arbiter).
//   ECC_WIDTH        default operand/result width
//   inv_arb_state_e  inversion arbiter FSM state
//   ERR_NONE/ABORT   rsp_err encoding (1 = rejected operands or timeout)
package ecc_ctrl_pkg;

    localparam int ECC_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } inv_arb_state_e;

    localparam logic ERR_NONE  = 1'b0;
    localparam logic ERR_ABORT = 1'b1;

endpackage

// File: rtl/ecc_rr_arbiter.sv
// ecc_rr_arbiter: combinational round-robin picker shared by the ECC
// shared-unit arbiters. Grants the first set request at or above ptr,
// wrapping past NUM_REQ-1 back to 0.
//   req        in   NUM_REQ  request vector
//   ptr        in   IDX_W    highest-priority index this cycle
//   grant      out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx  out  IDX_W    index of the granted requester
module ecc_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;
    int   idx;

    // NOTE: every output of this block gets a default before the loop, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ecc_inv_arbiter.sv
// ecc_inv_arbiter: shares one multi-cycle modular inversion unit among
// NUM_REQ ECC requesters. Round-robin grant in IDLE, operand check on
// accept, one-cycle start pulse, watchdog while waiting, and a
// valid/ready response returned to the owner.
//   req_valid_i/req_ready_o/req_a_i/req_p_i  request channel per requester
//   rsp_valid_o/rsp_ready_i                  response handshake, one-hot owner
//   rsp_result_o/rsp_err_o                   shared response payload
//   inv_a_o/inv_p_o/inv_start_o              operands and start to the unit
//   inv_finish_i/inv_result_i                completion from the unit
//   busy_o                                   arbiter not idle
module ecc_inv_arbiter
    import ecc_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = ECC_WIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_p_i,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    input  logic [NUM_REQ-1:0]              rsp_ready_i,
    output logic [WIDTH-1:0]                rsp_result_o,
    output logic                            rsp_err_o,
    output logic [WIDTH-1:0]                inv_a_o,
    output logic [WIDTH-1:0]                inv_p_o,
    output logic                            inv_start_o,
    input  logic                            inv_finish_i,
    input  logic [WIDTH-1:0]                inv_result_i,
    output logic                            busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    inv_arb_state_e     state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [WD_W-1:0]    wdog;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_p;
    logic               bad_operands;
    logic [NUM_REQ-1:0] owner_oh;
    logic [IDX_W-1:0]   next_ptr;

    ecc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is offered only to the granted requester and only in IDLE, so
    // any set bit of req_ready_o is also a completed request handshake.
    assign req_ready_o = (state == ST_IDLE) ? grant : '0;

    assign sel_a = req_a_i[grant_idx];
    assign sel_p = req_p_i[grant_idx];

    // An inverse exists and the unit is safe to run only for an odd modulus
    // of at least 3 and a nonzero, fully reduced operand.
    assign bad_operands = (sel_a == '0) || (sel_a >= sel_p) ||
                          (sel_p < WIDTH'(3)) || !sel_p[0];

    assign owner_oh = NUM_REQ'(1) << owner;
    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy_o   = (state != ST_IDLE);

    // NOTE: all state and registered outputs update with non-blocking
    // assignments so every branch sees the values from before this edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            wdog         <= '0;
            inv_a_o      <= '0;
            inv_p_o      <= '0;
            inv_start_o  <= 1'b0;
            rsp_valid_o  <= '0;
            rsp_result_o <= '0;
            rsp_err_o    <= ERR_NONE;
        end else begin
            inv_start_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner   <= grant_idx;
                        inv_a_o <= sel_a;
                        inv_p_o <= sel_p;
                        if (bad_operands) begin
                            rsp_valid_o  <= grant;
                            rsp_result_o <= '0;
                            rsp_err_o    <= ERR_ABORT;
                            state        <= ST_RESP;
                        end else begin
                            inv_start_o <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A finish seen here belongs to an earlier run; ignore it.
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (inv_finish_i) begin
                        rsp_valid_o  <= owner_oh;
                        rsp_result_o <= inv_result_i;
                        rsp_err_o    <= ERR_NONE;
                        state        <= ST_RESP;
                    end else if (wdog == WD_LAST) begin
                        rsp_valid_o  <= owner_oh;
                        rsp_result_o <= '0;
                        rsp_err_o    <= ERR_ABORT;
                        state        <= ST_RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[owner]) begin
                        rsp_valid_o  <= '0;
                        rsp_result_o <= '0;
                        rsp_err_o    <= ERR_NONE;
                        rr_ptr       <= next_ptr;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_inv_arbiter.sv
// tb_ecc_inv_arbiter: self-checking bench for ecc_inv_arbiter with a
// behavioural inversion unit (configurable latency, or never finishing).
// Expected responses are queued when stimulus is driven and compared when
// rsp_valid_o appears.
module tb_ecc_inv_arbiter;

    localparam int NR = 4;
    localparam int W  = 64;
    localparam int TO = 16;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0]         req_ready;
    logic [NR-1:0][W-1:0]  req_a;
    logic [NR-1:0][W-1:0]  req_p;
    logic [NR-1:0]         rsp_valid;
    logic [NR-1:0]         rsp_ready;
    logic [W-1:0]          rsp_result;
    logic                  rsp_err;
    logic [W-1:0]          inv_a;
    logic [W-1:0]          inv_p;
    logic                  inv_start;
    logic                  inv_finish;
    logic [W-1:0]          inv_result;
    logic                  busy;

    logic         rv [NR];
    logic [W-1:0] ra [NR];
    logic [W-1:0] rp [NR];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   acc_cyc [NR];

    int           model_lat = 5;
    bit           model_en  = 1'b1;
    bit           spurious  = 1'b0;
    bit           armed     = 1'b0;
    int           cd        = 0;
    logic [W-1:0] ma, mp;

    ecc_inv_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_p_i      (req_p),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_err_o    (rsp_err),
        .inv_a_o      (inv_a),
        .inv_p_o      (inv_p),
        .inv_start_o  (inv_start),
        .inv_finish_i (inv_finish),
        .inv_result_i (inv_result),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = rv[i];
            req_a[i]     = ra[i];
            req_p[i]     = rp[i];
        end
    end

    function automatic logic [W-1:0] modinv(input logic [W-1:0] a, input logic [W-1:0] p);
        for (longint unsigned x = 1; x < p; x++)
            if (((a * x) % p) == 1) return x;
        return '0;
    endfunction

    // Inversion unit model: finish model_lat cycles after the start cycle.
    always @(negedge clk) begin
        if (inv_start) start_cnt++;
        inv_finish = spurious;
        inv_result = spurious ? 64'hDEAD_BEEF : '0;
        if (!rst_n) begin
            armed = 1'b0;
        end else if (inv_start) begin
            armed = 1'b1;
            cd    = model_lat;
            ma    = inv_a;
            mp    = inv_p;
        end else if (armed) begin
            cd--;
            if (cd == 0) begin
                armed = 1'b0;
                if (model_en) begin
                    inv_finish = 1'b1;
                    inv_result = modinv(ma, mp);
                end
            end
        end
    end

    task automatic push_exp(input int idx, input logic [W-1:0] res, input logic err);
        exp_t e;
        e.idx = idx;
        e.res = res;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic drive_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] p);
        bit ok = 1'b0;
        @(negedge clk);
        ra[idx] = a;
        rp[idx] = p;
        rv[idx] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (req_ready[idx]) begin
                ok = 1'b1;
                acc_cyc[idx] = cyc;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        rv[idx] = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout[%0d]: req_ready=%b, required accept", idx, req_ready);
        end
    endtask

    // Waits for a response, compares it against the scoreboard head, then
    // completes the handshake for the observed owner.
    task automatic collect(output int t_rsp);
        exp_t e;
        bit   seen = 1'b0;
        t_rsp = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL rsp_timeout: rsp_valid=%b, required a response", rsp_valid);
            return;
        end
        t_rsp = cyc;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: rsp_valid=%b, required none", rsp_valid);
        end else begin
            e = sb.pop_front();
            if (rsp_valid !== (NR'(1) << e.idx)) begin
                n_err++;
                $display("FAIL rsp_owner: got %b, required owner %0d", rsp_valid, e.idx);
            end
            n_vec++;
            if (rsp_result !== e.res) begin
                n_err++;
                $display("FAIL rsp_result: got %0d, required %0d", rsp_result, e.res);
            end
            n_vec++;
            if (rsp_err !== e.err) begin
                n_err++;
                $display("FAIL rsp_err: got %b, required %b", rsp_err, e.err);
            end
        end
        for (int i = 0; i < NR; i++)
            if (rsp_valid[i]) rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rsp_ready = '0;
        for (int i = 0; i < NR; i++) begin
            rv[i] = 1'b0;
            ra[i] = '0;
            rp[i] = '0;
        end
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({rsp_valid, req_ready, inv_start, busy, rsp_err, rsp_result, inv_a, inv_p} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rsp_valid=%b ready=%b start=%b busy=%b err=%b res=%0d",
                     rsp_valid, req_ready, inv_start, busy, rsp_err, rsp_result);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int t, s0;
        s0 = start_cnt;
        model_lat = 5;
        push_exp(1, 64'd5, 1'b0);
        drive_req(1, 64'd3, 64'd7);
        collect(t);
        n_vec++;
        if (t - acc_cyc[1] != 7) begin
            n_err++;
            $display("FAIL basic_latency: got %0d, required 7", t - acc_cyc[1]);
        end
        n_vec++;
        if (start_cnt - s0 != 1) begin
            n_err++;
            $display("FAIL basic_start_pulse: got %0d cycles, required 1", start_cnt - s0);
        end
        // Fastest unit: finish in the first WAIT cycle.
        model_lat = 1;
        push_exp(1, 64'd3, 1'b0);
        drive_req(1, 64'd5, 64'd7);
        collect(t);
        n_vec++;
        if (t - acc_cyc[1] != 3) begin
            n_err++;
            $display("FAIL min_latency: got %0d, required 3", t - acc_cyc[1]);
        end
    endtask

    task automatic test_round_robin();
        int t;
        do_reset();
        model_lat = 3;
        push_exp(0, 64'd6, 1'b0);
        push_exp(2, 64'd10, 1'b0);
        fork
            drive_req(0, 64'd2, 64'd11);
            drive_req(2, 64'd4, 64'd13);
        join_none
        collect(t);
        collect(t);
        wait fork;
        // rr_ptr now points at requester 3.
        push_exp(3, 64'd3, 1'b0);
        push_exp(0, 64'd5, 1'b0);
        fork
            drive_req(0, 64'd3, 64'd7);
            drive_req(3, 64'd5, 64'd7);
        join_none
        @(negedge clk);
        #2;
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL rr_grant: got %b, required 1000", req_ready);
        end
        collect(t);
        collect(t);
        wait fork;
    endtask

    task automatic test_reject();
        int t, s0;
        logic [W-1:0] av [3] = '{64'd0, 64'd9, 64'd3};
        logic [W-1:0] pv [3] = '{64'd7, 64'd7, 64'd8};
        s0 = start_cnt;
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 64'd0, 1'b1);
            drive_req(0, av[k], pv[k]);
            collect(t);
            n_vec++;
            if (t - acc_cyc[0] != 1) begin
                n_err++;
                $display("FAIL reject_latency[%0d]: got %0d, required 1", k, t - acc_cyc[0]);
            end
        end
        n_vec++;
        if (start_cnt != s0) begin
            n_err++;
            $display("FAIL reject_start: got %0d pulses, required 0", start_cnt - s0);
        end
    endtask

    task automatic test_timeout();
        int t;
        model_en = 1'b0;
        push_exp(2, 64'd0, 1'b1);
        drive_req(2, 64'd3, 64'd7);
        collect(t);
        n_vec++;
        if (t - acc_cyc[2] != TO + 2) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d, required %0d", t - acc_cyc[2], TO + 2);
        end
        model_en = 1'b1;
        model_lat = 1;
        push_exp(2, 64'd4, 1'b0);
        drive_req(2, 64'd3, 64'd11);
        collect(t);
        // Finish in the last watchdog cycle wins over the timeout.
        model_lat = TO;
        push_exp(1, 64'd6, 1'b0);
        drive_req(1, 64'd6, 64'd7);
        collect(t);
        n_vec++;
        if (t - acc_cyc[1] != TO + 2) begin
            n_err++;
            $display("FAIL finish_at_limit_latency: got %0d, required %0d", t - acc_cyc[1], TO + 2);
        end
        // One cycle later is too late: abort, late finish lands in RESP.
        model_lat = TO + 1;
        push_exp(1, 64'd0, 1'b1);
        drive_req(1, 64'd3, 64'd7);
        collect(t);
        model_lat = 2;
        push_exp(1, 64'd4, 1'b0);
        drive_req(1, 64'd2, 64'd7);
        collect(t);
    endtask

    task automatic test_stall();
        int t;
        bit seen = 1'b0;
        logic [NR-1:0] v0;
        logic [W-1:0]  r0;
        logic          e0;
        model_lat = 2;
        push_exp(1, 64'd3, 1'b0);
        push_exp(3, 64'd6, 1'b0);
        drive_req(1, 64'd5, 64'd7);
        fork
            drive_req(3, 64'd2, 64'd11);
        join_none
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                seen = 1'b1;
                break;
            end
        end
        v0 = rsp_valid;
        r0 = rsp_result;
        e0 = rsp_err;
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL stall_rsp: rsp_valid=%b, required a response", rsp_valid);
        end
        rsp_ready = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== v0 || rsp_result !== r0 || rsp_err !== e0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %b/%0d/%b, required %b/%0d/%b",
                         i, rsp_valid, rsp_result, rsp_err, v0, r0, e0);
            end
            n_vec++;
            if (req_ready !== '0) begin
                n_err++;
                $display("FAIL stall_ready[%0d]: got %b, required 0000", i, req_ready);
            end
        end
        rsp_ready = '0;
        collect(t);
        collect(t);
        wait fork;
    endtask

    task automatic test_reset_mid();
        int t;
        model_en = 1'b0;
        drive_req(0, 64'd3, 64'd7);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rsp_valid, req_ready, inv_start, busy, rsp_err, rsp_result, inv_a, inv_p} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: rsp_valid=%b ready=%b start=%b busy=%b err=%b",
                     rsp_valid, req_ready, inv_start, busy, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_en = 1'b1;
        @(posedge clk);
        #1;
        spurious = 1'b1;
        @(posedge clk);
        #1;
        spurious = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL spurious_finish[%0d]: rsp_valid=%b busy=%b, required 0/0", i, rsp_valid, busy);
            end
        end
        model_lat = 3;
        push_exp(1, 64'd3, 1'b0);
        drive_req(1, 64'd5, 64'd7);
        collect(t);
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = '0;
        inv_finish = 1'b0;
        inv_result = '0;
        for (int i = 0; i < NR; i++) begin
            rv[i] = 1'b0;
            ra[i] = '0;
            rp[i] = '0;
            acc_cyc[i] = 0;
        end
        #12;
        test_reset();
        test_basic();
        test_round_robin();
        test_reject();
        test_timeout();
        test_stall();
        test_reset_mid();
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
